pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-stage controller for the pipelined CPU. It owns the PC register and selects each cycle's next PC from sequential increment, jump redirect (ID stage) and branch redirect (MEM stage). It holds the PC on load-use stalls and drives the IF/ID write-enable and the flush controls for the pipeline registers. It replaces the bare PC register in the fetch path and adds saturating performance counters and a misaligned-target flag.

## Interface
- `ADDR_W`, 32: PC width.
- `RESET_VEC`, 32'h0000_0000: PC value after reset.
- `CNT_W`, 16: width of the performance counters.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `stall_i`  in  1  load-use hazard from the hazard unit; hold fetch.
- `jump_i`  in  1  jump decoded in ID.
- `jump_target_i`  in  ADDR_W  jump destination.
- `branch_taken_i`  in  1  branch resolved taken in MEM.
- `branch_target_i`  in  ADDR_W  branch destination.
- `pc_o`  out  ADDR_W  current fetch address (registered).
- `pc_plus4_o`  out  ADDR_W  `pc_o + 4`, modulo 2^ADDR_W.
- `fetch_valid_o`  out  1  instruction fetched at `pc_o` is architecturally valid.
- `if_id_write_o`  out  1  IF/ID register write enable.
- `if_id_flush_o`  out  1  zero IF/ID.
- `id_ex_flush_o`  out  1  zero ID/EX (bubble).
- `ex_mem_flush_o`  out  1  zero EX/MEM.
- `misalign_o`  out  1  sticky: a redirect target had nonzero bits [1:0].
- `stall_cnt_o`  out  CNT_W  saturating count of stalled cycles.
- `redirect_cnt_o`  out  CNT_W  saturating count of taken redirects (jumps and branches).
- `state_o`  out  2  FSM state, for debug.

## Operation
- FSM states, encoded as BOOT=0, RUN=1, STALL=2.
- Reset (`rst_i`=1 at an edge) gives:
  - `pc_o`=RESET_VEC, state=BOOT;
  - counters=0, `misalign_o`=0.
- BOOT lasts exactly one cycle:
  - `fetch_valid_o`=0, `if_id_write_o`=1;
  - all inputs are ignored and `pc_o` is not incremented;
  - next state is RUN.
- In RUN and STALL, requests are evaluated with priority branch > jump > stall > sequential. The older instruction wins.
- **Branch** (`branch_taken_i`=1):
  - next PC = `branch_target_i` with bits [1:0] forced to 0;
  - `if_id_flush_o`, `id_ex_flush_o` and `ex_mem_flush_o` are asserted this cycle;
  - `jump_i` and `stall_i` are ignored this cycle;
  - next state is RUN; `redirect_cnt_o` increments.
- **Jump** (`jump_i`=1, no branch):
  - next PC = `jump_target_i` with bits [1:0] forced to 0;
  - `if_id_flush_o`=1; `stall_i` is ignored;
  - next state is RUN; `redirect_cnt_o` increments.
- **Stall** (`stall_i`=1, no redirect):
  - PC is held, `if_id_write_o`=0, `id_ex_flush_o`=1;
  - next state is STALL; `stall_cnt_o` increments.
  - STALL persists while `stall_i`=1 and returns to RUN when `stall_i`=0. A branch or jump during STALL exits immediately.
- **Sequential** (no request): next PC = `pc_o + 4`.
- Otherwise `if_id_write_o`=1 and all flush outputs are 0.
- `fetch_valid_o`=1 in RUN and STALL.
- Misalignment: when the selected redirect target has bits [1:0] != 0, `misalign_o` sets and remains set until reset.
- Arithmetic: the increment wraps, so 32'hFFFF_FFFC + 4 = 32'h0000_0000. The wrap raises no flag.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- `pc_o`, `state_o`, counters and `misalign_o` are registered and update one edge after the cycle in which their cause is sampled.
- `if_id_write_o`, all flush outputs and `pc_plus4_o` are combinational from inputs and current state, valid in the same cycle. There is no register between a redirect input and the flush outputs.
- Redirect latency: a request sampled at edge N gives `pc_o` = target after edge N.
- Stall latency: `pc_o` is unchanged across the edge at which `stall_i`=1 is sampled.
- Reset mid-stall or mid-redirect: reset overrides everything. Flush and write outputs take their BOOT values in the cycle after the reset edge.
- While `rst_i`=1, combinational outputs are don't-care; the bench must not check them.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum (BOOT/RUN/STALL);
  - the `ADDR_W` default;
  - the `RESET_VEC` default;
  - the PC increment constant (4).
- One sub-module, `sat_counter` (width parameter, synchronous clear, increment, saturate), is instantiated twice for `stall_cnt_o` and `redirect_cnt_o`.
- The next-PC mux, the FSM and the flush decode live in `pc_sequencer`.

## Test plan
- Reset, then 3 idle cycles → `pc_o` = 0, 0, 4, 8; `fetch_valid_o` = 0, 1, 1, 1; `state_o` shows BOOT then RUN.
- `stall_i`=1 for 3 cycles starting at `pc_o`=8 → `pc_o` holds 8 for 3 cycles; `if_id_write_o`=0 and `id_ex_flush_o`=1 each cycle; `stall_cnt_o`=3; `pc_o`=12 one cycle after `stall_i` drops.
- `branch_taken_i`=1 (target 32'h100), `jump_i`=1 (target 32'h200) and `stall_i`=1 together → next `pc_o`=32'h100; all three flushes high that cycle; `redirect_cnt_o`=1; `stall_cnt_o` unchanged.
- `jump_i`=1 with target 32'h0000_0046 → `pc_o`=32'h44; `misalign_o`=1 and still 1 after 10 further cycles; `if_id_flush_o`=1 only in the jump cycle.
- Jump to 32'hFFFF_FFFC, then idle → `pc_o`=32'hFFFF_FFFC, then 32'h0000_0000; `pc_plus4_o`=0 while `pc_o`=32'hFFFF_FFFC.
- `CNT_W`=4 with 20 stall cycles, then `rst_i`=1 asserted while `stall_i` is still high → `stall_cnt_o` saturates at 15; after the reset edge `pc_o`=RESET_VEC, `state_o`=BOOT, counters=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and PC defaults.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF    = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam int unsigned PC_INC        = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, picks next PC from branch/jump/stall/sequential
// and decodes the pipeline write-enable and flush controls.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              fetch_valid_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              ex_mem_flush_o,
    output logic              misalign_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  redirect_cnt_o,
    output logic [1:0]        state_o
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              misalign_q, misalign_set;
    logic              stall_inc, redirect_inc;

    assign pc_inc = pc_q + ADDR_W'(PC_INC);

    // State, PC and sticky misalign flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if (misalign_set) begin
                misalign_q <= 1'b1;
            end
        end
    end

    // Next-state, next-PC and flush decode; branch (older) beats jump beats stall.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        fetch_valid_o  = 1'b0;
        if_id_write_o  = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        misalign_set   = 1'b0;
        stall_inc      = 1'b0;
        redirect_inc   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                fetch_valid_o = 1'b1;
                if (branch_taken_i) begin
                    pc_d           = {branch_target_i[ADDR_W-1:2], 2'b00};
                    if_id_flush_o  = 1'b1;
                    id_ex_flush_o  = 1'b1;
                    ex_mem_flush_o = 1'b1;
                    misalign_set   = |branch_target_i[1:0];
                    redirect_inc   = 1'b1;
                    state_d        = ST_RUN;
                end else if (jump_i) begin
                    pc_d          = {jump_target_i[ADDR_W-1:2], 2'b00};
                    if_id_flush_o = 1'b1;
                    misalign_set  = |jump_target_i[1:0];
                    redirect_inc  = 1'b1;
                    state_d       = ST_RUN;
                end else if (stall_i) begin
                    if_id_write_o = 1'b0;
                    id_ex_flush_o = 1'b1;
                    stall_inc     = 1'b1;
                    state_d       = ST_STALL;
                end else begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (redirect_inc),
        .cnt_o (redirect_cnt_o)
    );

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_inc;
    assign misalign_o = misalign_q;
    assign state_o    = 2'(state_q);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations (CNT_W=4 to reach saturation).
module tb_pc_sequencer;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              fetch_valid;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_mem_flush;
    logic              misalign;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  redirect_cnt;
    logic [1:0]        state;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (32'h0000_0000),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .pc_o            (pc),
        .pc_plus4_o      (pc_plus4),
        .fetch_valid_o   (fetch_valid),
        .if_id_write_o   (if_id_write),
        .if_id_flush_o   (if_id_flush),
        .id_ex_flush_o   (id_ex_flush),
        .ex_mem_flush_o  (ex_mem_flush),
        .misalign_o      (misalign),
        .stall_cnt_o     (stall_cnt),
        .redirect_cnt_o  (redirect_cnt),
        .state_o         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        jump_target = '0; branch_target = '0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset then idle: pc 0,0,4,8
        chk("rst_pc", pc, 32'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("boot_fv", 32'(fetch_valid), 32'd0);
        chk("boot_wr", 32'(if_id_write), 32'd1);
        chk("rst_scnt", 32'(stall_cnt), 32'd0);
        chk("rst_rcnt", 32'(redirect_cnt), 32'd0);
        chk("rst_mis", 32'(misalign), 32'd0);
        step();
        chk("idle1_pc", pc, 32'h0);
        chk("idle1_state", 32'(state), 32'd1);
        chk("idle1_fv", 32'(fetch_valid), 32'd1);
        step();
        chk("idle2_pc", pc, 32'h4);
        step();
        chk("idle3_pc", pc, 32'h8);

        // Three stall cycles at pc=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pc", pc, 32'h8);
            chk("stall_wr", 32'(if_id_write), 32'd0);
            chk("stall_idex", 32'(id_ex_flush), 32'd1);
            chk("stall_ifid", 32'(if_id_flush), 32'd0);
            step();
        end
        chk("stall_hold_pc", pc, 32'h8);
        chk("stall_cnt3", 32'(stall_cnt), 32'd3);
        chk("stall_state", 32'(state), 32'd2);
        stall = 1'b0;
        #1;
        chk("unstall_wr", 32'(if_id_write), 32'd1);
        chk("unstall_idex", 32'(id_ex_flush), 32'd0);
        step();
        chk("unstall_pc", pc, 32'hC);
        chk("unstall_state", 32'(state), 32'd1);

        // Branch + jump + stall together: branch wins
        branch_taken = 1'b1; branch_target = 32'h100;
        jump = 1'b1; jump_target = 32'h200;
        stall = 1'b1;
        #1;
        chk("br_ifid", 32'(if_id_flush), 32'd1);
        chk("br_idex", 32'(id_ex_flush), 32'd1);
        chk("br_exmem", 32'(ex_mem_flush), 32'd1);
        chk("br_wr", 32'(if_id_write), 32'd1);
        step();
        branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
        chk("br_pc", pc, 32'h100);
        chk("br_rcnt", 32'(redirect_cnt), 32'd1);
        chk("br_scnt", 32'(stall_cnt), 32'd3);
        chk("br_mis", 32'(misalign), 32'd0);

        // Misaligned jump target
        jump = 1'b1; jump_target = 32'h0000_0046;
        #1;
        chk("jmp_ifid", 32'(if_id_flush), 32'd1);
        chk("jmp_idex", 32'(id_ex_flush), 32'd0);
        chk("jmp_exmem", 32'(ex_mem_flush), 32'd0);
        step();
        jump = 1'b0;
        chk("jmp_pc", pc, 32'h44);
        chk("jmp_mis", 32'(misalign), 32'd1);
        chk("jmp_rcnt", 32'(redirect_cnt), 32'd2);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("post_jmp_ifid", 32'(if_id_flush), 32'd0);
            step();
        end
        chk("mis_sticky", 32'(misalign), 32'd1);
        chk("post_jmp_pc", pc, 32'h6C);

        // Wrap at top of address space
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0);
        step();
        chk("wrapped_pc", pc, 32'h0);
        chk("wrap_rcnt", 32'(redirect_cnt), 32'd3);

        // Saturate stall counter at 15 then reset mid-stall
        stall = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("sat_cnt15", 32'(stall_cnt), 32'd15);
        for (int i = 0; i < 8; i++) step();
        chk("sat_hold15", 32'(stall_cnt), 32'd15);
        chk("sat_pc", pc, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_state", 32'(state), 32'd0);
        chk("rst2_scnt", 32'(stall_cnt), 32'd0);
        chk("rst2_rcnt", 32'(redirect_cnt), 32'd0);
        chk("rst2_mis", 32'(misalign), 32'd0);
        chk("rst2_wr", 32'(if_id_write), 32'd1);
        chk("rst2_idex", 32'(id_ex_flush), 32'd0);
        chk("rst2_fv", 32'(fetch_valid), 32'd0);
        step();
        chk("boot_ignore_pc", pc, 32'h0);
        chk("boot_ignore_scnt", 32'(stall_cnt), 32'd0);
        chk("boot_to_run", 32'(state), 32'd1);
        stall = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
